// File: rtl/parking_sensor_decoder.sv
// parking_sensor_decoder: synchronise, debounce and decode a/b sensor pairs into entry/exit/error pulses
module parking_sensor_decoder #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int CNT_W           = 17,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic SENS_A,
    input  logic SENS_B,
    output logic ENTRY,
    output logic EXIT,
    output logic ERR,
    output logic A_DB,
    output logic B_DB
);
    typedef enum logic [2:0] {IDLE, E1, E2, E3, X1, X2, X3, WAIT} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [1:0] raw, s1, s2, db;
    logic [CNT_W-1:0] cnt [2];
    state_t state;
    assign raw = {SENS_A, SENS_B} ^ {2{ACTIVE_LOW}};
    assign A_DB = db[1];
    assign B_DB = db[0];
    // bit 1 carries channel a, bit 0 channel b, so db reads directly as the {a,b} pair
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1  <= '0;
            s2  <= '0;
            db  <= '0;
            cnt <= '{default: '0};
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == db[i]) cnt[i] <= '0;
                else if (cnt[i] == LAST) begin
                    cnt[i] <= '0;
                    db[i]  <= ~db[i];
                end else cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            ENTRY <= 1'b0;
            EXIT  <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            ENTRY <= 1'b0;
            EXIT  <= 1'b0;
            ERR   <= 1'b0;
            unique case (state)
                IDLE: case (db)
                    2'b10:   state <= E1;
                    2'b01:   state <= X1;
                    2'b11:   begin ERR <= 1'b1; state <= WAIT; end
                    default: state <= IDLE;
                endcase
                E1: case (db)
                    2'b11:   state <= E2;
                    2'b00:   state <= IDLE;
                    2'b01:   begin ERR <= 1'b1; state <= WAIT; end
                    default: state <= E1;
                endcase
                E2: case (db)
                    2'b01:   state <= E3;
                    2'b10:   state <= E1;
                    2'b00:   begin ERR <= 1'b1; state <= IDLE; end
                    default: state <= E2;
                endcase
                E3: case (db)
                    2'b00:   begin ENTRY <= 1'b1; state <= IDLE; end
                    2'b11:   state <= E2;
                    2'b10:   begin ERR <= 1'b1; state <= WAIT; end
                    default: state <= E3;
                endcase
                X1: case (db)
                    2'b11:   state <= X2;
                    2'b00:   state <= IDLE;
                    2'b10:   begin ERR <= 1'b1; state <= WAIT; end
                    default: state <= X1;
                endcase
                X2: case (db)
                    2'b10:   state <= X3;
                    2'b01:   state <= X1;
                    2'b00:   begin ERR <= 1'b1; state <= IDLE; end
                    default: state <= X2;
                endcase
                X3: case (db)
                    2'b00:   begin EXIT <= 1'b1; state <= IDLE; end
                    2'b11:   state <= X2;
                    2'b01:   begin ERR <= 1'b1; state <= WAIT; end
                    default: state <= X3;
                endcase
                WAIT: state <= (db == 2'b00) ? IDLE : WAIT;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
